// File: rtl/bias_loader_pkg.sv
// Shared types and constants for the bias loader.
package bias_loader_pkg;

    // Project-wide two's-complement numeric width used across the datapath.
    localparam int NUM_WIDTH_DEFAULT = 16;

    // Controller states: accept config, take the burst, prime the output, serve channels.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PRIME = 2'd2,
        SERVE = 2'd3
    } bias_state_t;

endpackage

// File: rtl/bias_loader_if.sv
// Config, upstream bias stream and channel-step signals of the bias loader.
interface bias_loader_if
    import bias_loader_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEFAULT,
    parameter int DEPTH     = 8
);
    localparam int DEPTH_W = $clog2(DEPTH);

    logic                 clear;
    logic                 cfg_valid;
    logic [DEPTH_W:0]     cfg_num;
    logic                 cfg_ready;
    logic [NUM_WIDTH-1:0] up_data;
    logic                 up_valid;
    logic                 up_ready;
    logic                 next;
    logic [NUM_WIDTH-1:0] bias;
    logic                 bias_valid;

    // The bias loader itself.
    modport slave (
        input  clear, cfg_valid, cfg_num, up_data, up_valid, next,
        output cfg_ready, up_ready, bias, bias_valid
    );

    // Layer sequencer / upstream source.
    modport master (
        output clear, cfg_valid, cfg_num, up_data, up_valid, next,
        input  cfg_ready, up_ready, bias, bias_valid
    );

endinterface

// File: rtl/bias_loader.sv
// Bias supply stage: loads a per-layer burst of bias words into a small
// register file, then presents one registered word per output channel,
// stepping on next and wrapping at the configured channel count.
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEFAULT,
    parameter int DEPTH     = 8
) (
    input  logic         clk,
    input  logic         rst,
    bias_loader_if.slave bus
);
    localparam int DEPTH_W = $clog2(DEPTH);
    localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W + 1)'(DEPTH);

    bias_state_t          state_q, state_d;
    logic [DEPTH_W:0]     num_q, num_d;
    logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0]   rd_ptr_n;
    logic [DEPTH_W:0]     last_idx;
    logic [NUM_WIDTH-1:0] bias_q, bias_d;
    logic                 bias_valid_q, bias_valid_d;
    logic                 wr_en;
    logic [NUM_WIDTH-1:0] mem [DEPTH];

    assign last_idx = num_q - 1'b1;

    // Following read index, wrapping to entry 0 after the last loaded channel.
    always_comb begin
        rd_ptr_n = ({1'b0, rd_ptr_q} == last_idx) ? '0 : rd_ptr_q + 1'b1;
    end

    // Next-state and datapath decode; clear overrides every other request.
    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d      = state_q;
        num_d        = num_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        bias_d       = bias_q;
        bias_valid_d = bias_valid_q;
        wr_en        = 1'b0;

        if (bus.clear) begin
            state_d      = IDLE;
            bias_d       = '0;
            bias_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cfg_valid && (bus.cfg_num != '0)) begin
                        num_d    = (bus.cfg_num > DEPTH_CNT) ? DEPTH_CNT : bus.cfg_num;
                        wr_ptr_d = '0;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    if (bus.up_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if ({1'b0, wr_ptr_q} == last_idx) begin
                            state_d = PRIME;
                        end
                    end
                end
                PRIME: begin
                    bias_d       = mem[0];
                    rd_ptr_d     = '0;
                    bias_valid_d = 1'b1;
                    state_d      = SERVE;
                end
                SERVE: begin
                    if (bus.next) begin
                        rd_ptr_d = rd_ptr_n;
                        bias_d   = mem[rd_ptr_n];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking assignments so each samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            num_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            bias_q       <= '0;
            bias_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            bias_q       <= bias_d;
            bias_valid_q <= bias_valid_d;
        end
    end

    // Bias register file write port.
    always_ff @(posedge clk) begin
        // NOTE: no reset on the array; entries are only read after a full load rewrites them.
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.up_data;
        end
    end

    assign bus.cfg_ready  = (state_q == IDLE);
    assign bus.up_ready   = (state_q == LOAD);
    assign bus.bias       = bias_q;
    assign bus.bias_valid = bias_valid_q;

    // Invariants of the controller.
    a_valid_in_serve: assert property (@(posedge clk) disable iff (rst)
        bias_valid_q |-> (state_q == SERVE));
    a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.cfg_ready && bus.up_ready));
    a_rd_ptr_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE) |-> ({1'b0, rd_ptr_q} < num_q));

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: a reference model of the register
// file predicts each presented bias word into a queue, popped on output.
module tb_bias_loader;
    import bias_loader_pkg::*;

    localparam int NW    = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bias_loader_if #(.NUM_WIDTH(NW), .DEPTH(DEPTH)) bus ();

    bias_loader #(.NUM_WIDTH(NW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NW-1:0] exp_q  [$];
    logic [NW-1:0] word_q [$];
    logic [NW-1:0] m_mem  [DEPTH];
    int            m_num  = 0;
    int            m_rd   = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Config + burst of m_num words; checks the PRIME cycle and the first presented word.
    task automatic load(input int cfg, input bit gaps, input string name);
        int            n_eff;
        logic [NW-1:0] w;
        logic [NW-1:0] e;
        n_eff = (cfg > DEPTH) ? DEPTH : cfg;
        bus.cfg_num   = cfg[DW:0];
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < n_eff; i++) begin
            if (gaps) begin
                bus.up_valid = 1'b0;
                bus.up_data  = 16'hBAD0;
                step();
            end
            n_checks++;
            if (bus.up_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s up_ready word %0d: got %b expected 1", name, i, bus.up_ready);
            end
            w = word_q.pop_front();
            m_mem[i] = w;
            bus.up_data  = w;
            bus.up_valid = 1'b1;
            step();
        end
        // Valid stays high during PRIME; nothing more may be accepted.
        bus.up_data = 16'hDEAD;
        n_checks++;
        if ({bus.up_ready, bus.bias_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s prime up_ready/bias_valid: got %b expected 00", name,
                     {bus.up_ready, bus.bias_valid});
        end
        m_num = n_eff;
        m_rd  = 0;
        exp_q.push_back(m_mem[0]);
        step();
        bus.up_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.bias_valid, bus.bias} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL %s first bias: got valid=%b bias=%h expected valid=1 bias=%h",
                     name, bus.bias_valid, bus.bias, e);
        end
        n_checks++;
        if ({bus.cfg_ready, bus.up_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s serve readies: got %b expected 00", name, {bus.cfg_ready, bus.up_ready});
        end
    endtask

    // n next pulses; with holds, an idle cycle after each must keep bias unchanged.
    task automatic serve(input int n, input bit holds, input string name);
        logic [NW-1:0] e;
        for (int i = 0; i < n; i++) begin
            m_rd = (m_rd == m_num - 1) ? 0 : m_rd + 1;
            exp_q.push_back(m_mem[m_rd]);
            bus.next = 1'b1;
            step();
            bus.next = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.bias_valid, bus.bias} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL %s next %0d: got valid=%b bias=%h expected valid=1 bias=%h",
                         name, i, bus.bias_valid, bus.bias, e);
            end
            if (holds) begin
                step();
                n_checks++;
                if ({bus.bias_valid, bus.bias} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL %s hold %0d: got valid=%b bias=%h expected valid=1 bias=%h",
                             name, i, bus.bias_valid, bus.bias, e);
                end
            end
        end
    endtask

    // One clear cycle (optionally with next) and check of the idle output state.
    task automatic do_clear(input bit with_next, input string name);
        bus.clear = 1'b1;
        bus.next  = with_next;
        step();
        bus.clear = 1'b0;
        bus.next  = 1'b0;
        m_rd      = 0;
        n_checks++;
        if ({bus.cfg_ready, bus.up_ready, bus.bias_valid, bus.bias} !== {3'b100, 16'h0000}) begin
            n_fail++;
            $display("FAIL %s idle outputs: got %h expected %h", name,
                     {bus.cfg_ready, bus.up_ready, bus.bias_valid, bus.bias}, {3'b100, 16'h0000});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset cfg_ready: got %b expected 1", bus.cfg_ready); end
        n_checks++;
        if (bus.up_ready !== 1'b0) begin n_fail++; $display("FAIL reset up_ready: got %b expected 0", bus.up_ready); end
        n_checks++;
        if (bus.bias !== 16'h0000) begin n_fail++; $display("FAIL reset bias: got %h expected 0000", bus.bias); end
        n_checks++;
        if (bus.bias_valid !== 1'b0) begin n_fail++; $display("FAIL reset bias_valid: got %b expected 0", bus.bias_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_basic();
        word_q.push_back(16'h0010);
        word_q.push_back(16'hFFF0);
        word_q.push_back(16'h7FFF);
        load(3, 1'b0, "basic");
        serve(3, 1'b0, "basic");
        do_clear(1'b0, "basic");
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 4; i++) word_q.push_back(NW'($urandom));
        load(4, 1'b1, "gapped");
        serve(5, 1'b1, "gapped");
        do_clear(1'b0, "gapped");
    endtask

    task automatic test_zero_count();
        bus.cfg_num   = '0;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        n_checks++;
        if ({bus.cfg_ready, bus.up_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_count readies: got %b expected 10", {bus.cfg_ready, bus.up_ready});
        end
        bus.up_valid = 1'b1;
        bus.up_data  = 16'h1234;
        step();
        bus.up_valid = 1'b0;
        n_checks++;
        if ({bus.cfg_ready, bus.up_ready, bus.bias_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_count idle: got %b expected 100", {bus.cfg_ready, bus.up_ready, bus.bias_valid});
        end
    endtask

    task automatic test_over_count();
        for (int i = 0; i < DEPTH; i++) word_q.push_back(NW'(16'h8001 ^ (i * 16'h1111)));
        load(DEPTH + 3, 1'b0, "over_count");
        serve(DEPTH + 1, 1'b0, "over_count");
        do_clear(1'b0, "over_count");
    endtask

    task automatic test_single();
        word_q.push_back(16'h8000);
        load(1, 1'b0, "single");
        serve(3, 1'b0, "single");
        do_clear(1'b0, "single");
    endtask

    task automatic test_clear_load();
        bus.cfg_num   = 4'd5;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.up_data  = NW'(16'h0A00 + i);
            bus.up_valid = 1'b1;
            step();
        end
        // Third word offered in the same cycle as clear.
        bus.up_data = 16'h0A02;
        do_clear(1'b0, "clear_load");
        bus.up_valid = 1'b0;
        for (int i = 0; i < 5; i++) word_q.push_back(NW'(16'hC100 + 16'h0101 * i));
        load(5, 1'b0, "reload");
        serve(5, 1'b0, "reload");
    endtask

    task automatic test_priority();
        logic [NW-1:0] held;
        do_clear(1'b1, "clear_with_next");
        word_q.push_back(16'h1111);
        word_q.push_back(16'h2222);
        word_q.push_back(16'h3333);
        load(3, 1'b0, "prio");
        serve(1, 1'b0, "prio");
        held = m_mem[m_rd];
        bus.cfg_num   = 4'd2;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        n_checks++;
        if ({bus.cfg_ready, bus.up_ready, bus.bias_valid, bus.bias} !== {3'b001, held}) begin
            n_fail++;
            $display("FAIL cfg_in_serve: got %h expected %h",
                     {bus.cfg_ready, bus.up_ready, bus.bias_valid, bus.bias}, {3'b001, held});
        end
        serve(4, 1'b0, "prio_after_cfg");
    endtask

    task automatic test_async_reset();
        serve(1, 1'b0, "async_pre");
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.cfg_ready, bus.up_ready, bus.bias_valid, bus.bias} !== {3'b100, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset outputs: got %h expected %h",
                     {bus.cfg_ready, bus.up_ready, bus.bias_valid, bus.bias}, {3'b100, 16'h0000});
        end
        @(negedge clk);
        rst  = 1'b0;
        m_rd = 0;
        step();
        n_checks++;
        if ({bus.cfg_ready, bus.bias_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL after_reset idle: got %b expected 10", {bus.cfg_ready, bus.bias_valid});
        end
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_num   = '0;
        bus.up_data   = '0;
        bus.up_valid  = 1'b0;
        bus.next      = 1'b0;
        #1;
        test_reset();
        test_load_basic();
        test_gapped();
        test_zero_count();
        test_over_count();
        test_single();
        test_clear_load();
        test_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
